// File: rtl/glb_pkg.sv
// Shared constants and helpers for the GLB bank arbiter and its round-robin arbiters.
package glb_pkg;

   localparam logic CLS_READ  = 1'b0;
   localparam logic CLS_WRITE = 1'b1;

   // OR of the indices of all set bits, which is the index when the input is one-hot.
   function automatic int unsigned onehot2bin(input logic [31:0] oh);
      int unsigned idx;
      idx = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (oh[i]) idx = idx | i;
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a priority pointer that moves past the winner on each accepted grant.
module rr_arbiter
   import glb_pkg::*;
#(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx
);

   logic [IW-1:0] ptr_q, ptr_d;

   // Search starts at the pointer; with no request the index falls back to the pointer.
   always_comb begin
      int unsigned idx;
      logic        found;
      idx   = 0;
      found = 1'b0;
      gnt   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = (32'(ptr_q) + k) % N;
         if (!found && req[idx]) begin
            gnt[idx] = 1'b1;
            found    = 1'b1;
         end
      end
      gnt_idx = found ? IW'(onehot2bin(32'(gnt))) : ptr_q;
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance && (N > 1)) begin
         ptr_d = (32'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/glb_bank_arbiter.sv
// Shares one GLB SRAM bank between round-robin read and write requester groups.
module glb_bank_arbiter
   import glb_pkg::*;
#(
   parameter int unsigned NUM_RD     = 4,
   parameter int unsigned NUM_WR     = 2,
   parameter int unsigned SRAM_WIDTH = 256,
   parameter int unsigned SRAM_WORD  = 64,
   parameter int unsigned ADDR_WIDTH = $clog2(SRAM_WORD),
   parameter int unsigned DUAL_PORT  = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_RD-1:0]            rd_req_vld,
   input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_req_addr,
   output logic [NUM_RD-1:0]            rd_req_rdy,
   output logic [NUM_RD-1:0]            rd_rsp_vld,
   output logic [SRAM_WIDTH-1:0]        rd_rsp_dat,
   input  logic [NUM_WR-1:0]            wr_req_vld,
   input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_req_addr,
   input  logic [NUM_WR*SRAM_WIDTH-1:0] wr_req_dat,
   output logic [NUM_WR-1:0]            wr_req_rdy,
   output logic [ADDR_WIDTH-1:0]        ram_addr_r,
   output logic [ADDR_WIDTH-1:0]        ram_addr_w,
   output logic                         ram_read_en,
   output logic                         ram_write_en,
   output logic [SRAM_WIDTH-1:0]        ram_data_in,
   input  logic [SRAM_WIDTH-1:0]        ram_data_out
);

   localparam int unsigned RD_IW = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
   localparam int unsigned WR_IW = (NUM_WR > 1) ? $clog2(NUM_WR) : 1;

   logic [NUM_RD-1:0]     rd_win;
   logic [RD_IW-1:0]      rd_idx;
   logic [NUM_WR-1:0]     wr_win;
   logic [WR_IW-1:0]      wr_idx;
   logic [ADDR_WIDTH-1:0] rd_addr, wr_addr;
   logic                  rd_any, wr_any;
   logic                  grant_rd, grant_wr;
   logic                  last_cls_q, last_cls_d;
   logic [NUM_RD-1:0]     rsp_sel_q;
   logic                  rsp_pend_q;

   rr_arbiter #(
      .N (NUM_RD)
   ) u_rd_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (rd_req_vld),
      .advance (grant_rd),
      .gnt     (rd_win),
      .gnt_idx (rd_idx)
   );

   rr_arbiter #(
      .N (NUM_WR)
   ) u_wr_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (wr_req_vld),
      .advance (grant_wr),
      .gnt     (wr_win),
      .gnt_idx (wr_idx)
   );

   assign rd_addr = rd_req_addr[rd_idx*ADDR_WIDTH +: ADDR_WIDTH];
   assign wr_addr = wr_req_addr[wr_idx*ADDR_WIDTH +: ADDR_WIDTH];
   assign rd_any  = |rd_req_vld;
   assign wr_any  = |wr_req_vld;

   // Grants are suppressed while reset is held so no handshake completes into a cleared state.
   always_comb begin
      grant_rd = 1'b0;
      grant_wr = 1'b0;
      if (rst_n) begin
         if (DUAL_PORT != 0) begin
            grant_wr = wr_any;
            grant_rd = rd_any && !(wr_any && (rd_addr == wr_addr));
         end else begin
            grant_wr = wr_any && (!rd_any || (last_cls_q == CLS_READ));
            grant_rd = rd_any && (!wr_any || (last_cls_q == CLS_WRITE));
         end
      end
   end

   always_comb begin
      last_cls_d = last_cls_q;
      if (grant_wr) begin
         last_cls_d = CLS_WRITE;
      end else if (grant_rd) begin
         last_cls_d = CLS_READ;
      end
   end

   assign rd_req_rdy   = grant_rd ? rd_win : '0;
   assign wr_req_rdy   = grant_wr ? wr_win : '0;
   assign ram_read_en  = grant_rd;
   assign ram_write_en = grant_wr;
   assign ram_addr_r   = rd_addr;
   assign ram_addr_w   = wr_addr;
   assign ram_data_in  = wr_req_dat[wr_idx*SRAM_WIDTH +: SRAM_WIDTH];
   assign rd_rsp_vld   = rsp_pend_q ? rsp_sel_q : '0;
   assign rd_rsp_dat   = ram_data_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_cls_q <= CLS_READ;
         rsp_sel_q  <= '0;
         rsp_pend_q <= 1'b0;
      end else begin
         last_cls_q <= last_cls_d;
         rsp_sel_q  <= rd_req_rdy;
         rsp_pend_q <= grant_rd;
      end
   end

endmodule

// File: tb/tb_glb_bank_arbiter.sv
// Directed bench for glb_bank_arbiter: single-port and dual-port instances, each with a RAM model.
module tb_glb_bank_arbiter;

   localparam int AW = 6;
   localparam int DW = 256;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   // Single-port instance signals
   logic [3:0]      sp_rd_req_vld, sp_rd_req_rdy, sp_rd_rsp_vld;
   logic [4*AW-1:0] sp_rd_req_addr;
   logic [DW-1:0]   sp_rd_rsp_dat;
   logic [1:0]      sp_wr_req_vld, sp_wr_req_rdy;
   logic [2*AW-1:0] sp_wr_req_addr;
   logic [2*DW-1:0] sp_wr_req_dat;
   logic [AW-1:0]   sp_ram_addr_r, sp_ram_addr_w;
   logic            sp_ram_read_en, sp_ram_write_en;
   logic [DW-1:0]   sp_ram_data_in, sp_ram_data_out;
   logic [DW-1:0]   sp_mem [64];

   // Dual-port instance signals
   logic [3:0]      dp_rd_req_vld, dp_rd_req_rdy, dp_rd_rsp_vld;
   logic [4*AW-1:0] dp_rd_req_addr;
   logic [DW-1:0]   dp_rd_rsp_dat;
   logic [1:0]      dp_wr_req_vld, dp_wr_req_rdy;
   logic [2*AW-1:0] dp_wr_req_addr;
   logic [2*DW-1:0] dp_wr_req_dat;
   logic [AW-1:0]   dp_ram_addr_r, dp_ram_addr_w;
   logic            dp_ram_read_en, dp_ram_write_en;
   logic [DW-1:0]   dp_ram_data_in, dp_ram_data_out;
   logic [DW-1:0]   dp_mem [64];

   glb_bank_arbiter #(.DUAL_PORT(0)) dut_sp (
      .clk (clk), .rst_n (rst_n),
      .rd_req_vld (sp_rd_req_vld), .rd_req_addr (sp_rd_req_addr), .rd_req_rdy (sp_rd_req_rdy),
      .rd_rsp_vld (sp_rd_rsp_vld), .rd_rsp_dat (sp_rd_rsp_dat),
      .wr_req_vld (sp_wr_req_vld), .wr_req_addr (sp_wr_req_addr), .wr_req_dat (sp_wr_req_dat),
      .wr_req_rdy (sp_wr_req_rdy),
      .ram_addr_r (sp_ram_addr_r), .ram_addr_w (sp_ram_addr_w), .ram_read_en (sp_ram_read_en),
      .ram_write_en (sp_ram_write_en), .ram_data_in (sp_ram_data_in),
      .ram_data_out (sp_ram_data_out)
   );

   glb_bank_arbiter #(.DUAL_PORT(1)) dut_dp (
      .clk (clk), .rst_n (rst_n),
      .rd_req_vld (dp_rd_req_vld), .rd_req_addr (dp_rd_req_addr), .rd_req_rdy (dp_rd_req_rdy),
      .rd_rsp_vld (dp_rd_rsp_vld), .rd_rsp_dat (dp_rd_rsp_dat),
      .wr_req_vld (dp_wr_req_vld), .wr_req_addr (dp_wr_req_addr), .wr_req_dat (dp_wr_req_dat),
      .wr_req_rdy (dp_wr_req_rdy),
      .ram_addr_r (dp_ram_addr_r), .ram_addr_w (dp_ram_addr_w), .ram_read_en (dp_ram_read_en),
      .ram_write_en (dp_ram_write_en), .ram_data_in (dp_ram_data_in),
      .ram_data_out (dp_ram_data_out)
   );

   // 1-cycle-latency RAMs; a same-cycle read and write to one address returns the old word.
   always @(posedge clk) begin
      if (sp_ram_write_en) sp_mem[sp_ram_addr_w] <= sp_ram_data_in;
      if (sp_ram_read_en) sp_ram_data_out <= sp_mem[sp_ram_addr_r];
      if (dp_ram_write_en) dp_mem[dp_ram_addr_w] <= dp_ram_data_in;
      if (dp_ram_read_en) dp_ram_data_out <= dp_mem[dp_ram_addr_r];
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      sp_rd_req_vld = '0; sp_rd_req_addr = '0; sp_wr_req_vld = '0;
      sp_wr_req_addr = '0; sp_wr_req_dat = '0;
      dp_rd_req_vld = '0; dp_rd_req_addr = '0; dp_wr_req_vld = '0;
      dp_wr_req_addr = '0; dp_wr_req_dat = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst_n = 1'b0;
      step();
      step();
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 1'b0;
      sp_rd_req_vld = 4'b1111;
      sp_wr_req_vld = 2'b11;
      step();
      checks++; if (sp_rd_req_rdy !== 4'b0000) begin errors++; $display("FAIL rst_rd_rdy got %b want 0000", sp_rd_req_rdy); end
      checks++; if (sp_wr_req_rdy !== 2'b00) begin errors++; $display("FAIL rst_wr_rdy got %b want 00", sp_wr_req_rdy); end
      checks++; if (sp_rd_rsp_vld !== 4'b0000) begin errors++; $display("FAIL rst_rsp_vld got %b want 0000", sp_rd_rsp_vld); end
      checks++; if ({sp_ram_read_en, sp_ram_write_en} !== 2'b00) begin errors++; $display("FAIL rst_en got %b want 00", {sp_ram_read_en, sp_ram_write_en}); end
      do_reset();
   endtask

   task automatic test_single_read();
      logic [DW-1:0] pat;
      pat = {32{8'hA5}};
      sp_wr_req_vld = 2'b01;
      sp_wr_req_addr[0 +: AW] = 6'd5;
      sp_wr_req_dat[0 +: DW] = pat;
      #1;
      checks++; if (sp_wr_req_rdy !== 2'b01) begin errors++; $display("FAIL sr_wr_rdy got %b want 01", sp_wr_req_rdy); end
      checks++; if ({sp_ram_write_en, sp_ram_addr_w} !== {1'b1, 6'd5}) begin errors++; $display("FAIL sr_wr_port got %b/%0d want 1/5", sp_ram_write_en, sp_ram_addr_w); end
      step();
      sp_wr_req_vld = 2'b00;
      sp_rd_req_vld = 4'b0100;
      sp_rd_req_addr[2*AW +: AW] = 6'd5;
      #1;
      checks++; if (sp_rd_req_rdy !== 4'b0100) begin errors++; $display("FAIL sr_rdy got %b want 0100", sp_rd_req_rdy); end
      checks++; if ({sp_ram_read_en, sp_ram_addr_r} !== {1'b1, 6'd5}) begin errors++; $display("FAIL sr_rd_port got %b/%0d want 1/5", sp_ram_read_en, sp_ram_addr_r); end
      step();
      sp_rd_req_vld = 4'b0000;
      #1;
      checks++; if (sp_rd_rsp_vld !== 4'b0100) begin errors++; $display("FAIL sr_rsp_vld got %b want 0100", sp_rd_rsp_vld); end
      checks++; if (sp_rd_rsp_dat !== pat) begin errors++; $display("FAIL sr_rsp_dat got %h want %h", sp_rd_rsp_dat, pat); end
      step();
      checks++; if ({sp_rd_rsp_vld, sp_ram_read_en} !== 5'b0) begin errors++; $display("FAIL sr_idle got %b want 00000", {sp_rd_rsp_vld, sp_ram_read_en}); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_gnt, prev_gnt;
      do_reset();
      sp_rd_req_vld = 4'b1111;
      prev_gnt = 4'b0000;
      for (int k = 0; k < 5; k++) begin
         exp_gnt = 4'b0001 << (k % 4);
         #1;
         checks++; if (sp_rd_req_rdy !== exp_gnt) begin errors++; $display("FAIL rr_gnt[%0d] got %b want %b", k, sp_rd_req_rdy, exp_gnt); end
         checks++; if (sp_rd_rsp_vld !== prev_gnt) begin errors++; $display("FAIL rr_rsp[%0d] got %b want %b", k, sp_rd_rsp_vld, prev_gnt); end
         prev_gnt = exp_gnt;
         step();
      end
      sp_rd_req_vld = 4'b0000;
      #1;
      checks++; if (sp_rd_rsp_vld !== 4'b0001) begin errors++; $display("FAIL rr_last_rsp got %b want 0001", sp_rd_rsp_vld); end
   endtask

   task automatic test_class_conflict();
      do_reset();
      sp_rd_req_vld = 4'b0001;
      sp_rd_req_addr[0 +: AW] = 6'd11;
      sp_wr_req_vld = 2'b10;
      sp_wr_req_addr[AW +: AW] = 6'd10;
      sp_wr_req_dat[DW +: DW] = 256'h55;
      for (int k = 0; k < 4; k++) begin
         #1;
         if (k % 2 == 0) begin
            checks++; if ({sp_ram_write_en, sp_ram_read_en, sp_wr_req_rdy, sp_rd_req_rdy} !== 8'b10_10_0000) begin errors++; $display("FAIL cc_w[%0d] got %b want 10100000", k, {sp_ram_write_en, sp_ram_read_en, sp_wr_req_rdy, sp_rd_req_rdy}); end
         end else begin
            checks++; if ({sp_ram_write_en, sp_ram_read_en, sp_wr_req_rdy, sp_rd_req_rdy} !== 8'b01_00_0001) begin errors++; $display("FAIL cc_r[%0d] got %b want 01000001", k, {sp_ram_write_en, sp_ram_read_en, sp_wr_req_rdy, sp_rd_req_rdy}); end
         end
         step();
      end
      clear_inputs();
   endtask

   task automatic test_write_then_read();
      sp_wr_req_vld = 2'b10;
      sp_wr_req_addr[AW +: AW] = 6'd7;
      sp_wr_req_dat[DW +: DW] = 256'h1234;
      #1;
      checks++; if (sp_wr_req_rdy !== 2'b10) begin errors++; $display("FAIL wtr_wr_rdy got %b want 10", sp_wr_req_rdy); end
      step();
      sp_wr_req_vld = 2'b00;
      sp_rd_req_vld = 4'b0010;
      sp_rd_req_addr[AW +: AW] = 6'd7;
      #1;
      checks++; if (sp_rd_req_rdy !== 4'b0010) begin errors++; $display("FAIL wtr_rd_rdy got %b want 0010", sp_rd_req_rdy); end
      step();
      sp_rd_req_vld = 4'b0000;
      #1;
      checks++; if ({sp_rd_rsp_vld, sp_rd_rsp_dat} !== {4'b0010, 256'h1234}) begin errors++; $display("FAIL wtr_rsp got %b/%h want 0010/1234", sp_rd_rsp_vld, sp_rd_rsp_dat); end
      step();
   endtask

   task automatic test_reset_mid();
      do_reset();
      sp_rd_req_vld = 4'b0100;
      sp_rd_req_addr[2*AW +: AW] = 6'd5;
      #1;
      checks++; if (sp_rd_req_rdy !== 4'b0100) begin errors++; $display("FAIL rm_rdy got %b want 0100", sp_rd_req_rdy); end
      step();
      sp_rd_req_vld = 4'b0000;
      rst_n = 1'b0;
      #1;
      checks++; if (sp_rd_rsp_vld !== 4'b0000) begin errors++; $display("FAIL rm_rsp_in_rst got %b want 0000", sp_rd_rsp_vld); end
      step();
      rst_n = 1'b1;
      #1;
      checks++; if (sp_rd_rsp_vld !== 4'b0000) begin errors++; $display("FAIL rm_rsp_after got %b want 0000", sp_rd_rsp_vld); end
      sp_rd_req_vld = 4'b1111;
      #1;
      checks++; if (sp_rd_req_rdy !== 4'b0001) begin errors++; $display("FAIL rm_ptr got %b want 0001", sp_rd_req_rdy); end
      step();
      sp_rd_req_vld = 4'b0000;
      #1;
      checks++; if (sp_rd_rsp_vld !== 4'b0001) begin errors++; $display("FAIL rm_rsp_next got %b want 0001", sp_rd_rsp_vld); end
      step();
   endtask

   task automatic test_dual_port();
      do_reset();
      dp_rd_req_vld = 4'b0001;
      dp_rd_req_addr[0 +: AW] = 6'd3;
      dp_wr_req_vld = 2'b01;
      dp_wr_req_addr[0 +: AW] = 6'd3;
      dp_wr_req_dat[0 +: DW] = 256'hBEEF;
      #1;
      checks++; if ({dp_wr_req_rdy, dp_rd_req_rdy, dp_ram_write_en, dp_ram_read_en} !== 8'b01_0000_10) begin errors++; $display("FAIL dp_hazard got %b want 01000010", {dp_wr_req_rdy, dp_rd_req_rdy, dp_ram_write_en, dp_ram_read_en}); end
      step();
      dp_wr_req_vld = 2'b00;
      #1;
      checks++; if ({dp_rd_req_rdy, dp_ram_read_en, dp_ram_addr_r} !== {4'b0001, 1'b1, 6'd3}) begin errors++; $display("FAIL dp_retry got %b/%b/%0d want 0001/1/3", dp_rd_req_rdy, dp_ram_read_en, dp_ram_addr_r); end
      step();
      dp_wr_req_vld = 2'b01;
      dp_wr_req_addr[0 +: AW] = 6'd4;
      dp_wr_req_dat[0 +: DW] = 256'hCAFE;
      #1;
      checks++; if ({dp_rd_rsp_vld, dp_rd_rsp_dat} !== {4'b0001, 256'hBEEF}) begin errors++; $display("FAIL dp_new_data got %b/%h want 0001/beef", dp_rd_rsp_vld, dp_rd_rsp_dat); end
      checks++; if ({dp_wr_req_rdy, dp_rd_req_rdy, dp_ram_write_en, dp_ram_read_en} !== 8'b01_0001_11) begin errors++; $display("FAIL dp_both got %b want 01000111", {dp_wr_req_rdy, dp_rd_req_rdy, dp_ram_write_en, dp_ram_read_en}); end
      step();
      clear_inputs();
      #1;
      checks++; if ({dp_rd_rsp_vld, dp_rd_rsp_dat} !== {4'b0001, 256'hBEEF}) begin errors++; $display("FAIL dp_both_rsp got %b/%h want 0001/beef", dp_rd_rsp_vld, dp_rd_rsp_dat); end
      step();
   endtask

   initial begin
      clear_inputs();
      test_reset();
      test_single_read();
      test_round_robin();
      test_class_conflict();
      test_write_then_read();
      test_reset_mid();
      test_dual_port();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/glb_bank_arbiter.md
Name: glb_bank_arbiter

Overview:
- Shares one GLB SRAM bank (RAM primitive: addr_r/addr_w, read_en/write_en, 1-cycle read latency) between NUM_RD read requesters and NUM_WR write requesters.
- Issues at most one RAM access per cycle in single-port mode (DUAL_PORT=0), or one read plus one write per cycle in dual-port mode (DUAL_PORT=1).
- Returns read data one cycle after grant, with a per-requester valid pulse.
- Sits between the GLB bank instance and the PE-array / DMA-side bank clients.

Parameters:
- NUM_RD, 4, number of read requesters (>=1).
- NUM_WR, 2, number of write requesters (>=1).
- SRAM_WIDTH, 256, data width in bits.
- SRAM_WORD, 64, bank depth in words.
- ADDR_WIDTH, $clog2(SRAM_WORD), address width.
- DUAL_PORT, 0, 0 = single-port bank; 1 = separate read and write ports.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, reset, asynchronous, active-low.
- rd_req_vld, input, NUM_RD, read request valid, one bit per requester.
- rd_req_addr, input, NUM_RD*ADDR_WIDTH, read addresses; requester i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- rd_req_rdy, output, NUM_RD, read request accepted this cycle.
- rd_rsp_vld, output, NUM_RD, read data valid pulse for requester i.
- rd_rsp_dat, output, SRAM_WIDTH, read data (shared bus).
- wr_req_vld, input, NUM_WR, write request valid.
- wr_req_addr, input, NUM_WR*ADDR_WIDTH, write addresses.
- wr_req_dat, input, NUM_WR*SRAM_WIDTH, write data.
- wr_req_rdy, output, NUM_WR, write request accepted this cycle.
- ram_addr_r, output, ADDR_WIDTH, to RAM addr_r.
- ram_addr_w, output, ADDR_WIDTH, to RAM addr_w.
- ram_read_en, output, 1, to RAM read_en.
- ram_write_en, output, 1, to RAM write_en.
- ram_data_in, output, SRAM_WIDTH, to RAM data_in.
- ram_data_out, input, SRAM_WIDTH, from RAM data_out.

Behaviour:
- Handshake: a request is transferred when vld & rdy are both high in the same cycle.
- rdy is combinational from vld and arbiter state. Requesters must not make vld depend on rdy.
- Once vld is raised, the requester holds vld, addr and dat stable until it sees rdy.
- At most one rd_req_rdy bit and at most one wr_req_rdy bit are high in any cycle.
- Read grant at cycle T drives ram_read_en=1 and ram_addr_r=granted addr, combinationally, in cycle T.
  - At T+1: rd_rsp_vld[granted]=1 (single-cycle pulse) and rd_rsp_dat=ram_data_out.
  - No response backpressure: the requester must accept the data at T+1.
- Write grant at T drives ram_write_en=1, ram_addr_w and ram_data_in from the granted requester in cycle T.
- Within each class, round-robin arbitration:
  - A pointer register (rd_ptr, wr_ptr) marks the highest-priority index.
  - The pointer moves to (granted index + 1) mod N only on a grant.
  - Both pointers reset to 0.
- Class arbitration, DUAL_PORT=0:
  - Only one class is pending: grant that class.
  - Both classes pending: grant the class not served last, tracked by a 1-bit last_cls register.
  - last_cls updates on every grant and resets to READ, so the first conflict after reset grants the write.
- Class arbitration, DUAL_PORT=1:
  - A read and a write may both be granted in the same cycle.
  - Hazard: if the chosen read addr equals the chosen write addr, the write is granted and the read is held (rdy=0). The read is retried the next cycle.
- Idle outputs (no grant in the cycle): ram_read_en=0, ram_write_en=0. Addresses and data are don't-care but driven from the pointer-selected requester; they must not be X.
- Registered state: rd_ptr, wr_ptr, last_cls, rsp_sel (one-hot, NUM_RD bits), rsp_pend (1 bit).
- Reset values: all rdy=0, rd_rsp_vld=0, rd_rsp_dat=ram_data_out passthrough (value ignored while vld=0), ram_read_en=0, ram_write_en=0.
- Reset mid-operation: a grant in flight is dropped; no rd_rsp_vld pulse follows reset deassertion.
- Back-to-back reads to different requesters are legal every cycle. rsp_sel is overwritten each cycle, so the pulse ordering follows the grant ordering.
- NUM_RD=1 or NUM_WR=1: the pointer width is 1 and is held at 0.

Decomposition:
- Shared package glb_pkg:
  - constants CLS_READ=1'b0 and CLS_WRITE=1'b1;
  - function onehot2bin, used for the mux select.
- One sub-module, rr_arbiter:
  - parameter N;
  - inputs: req[N], advance;
  - outputs: gnt[N] (one-hot), gnt_idx;
  - contains its own pointer register.
- rr_arbiter is instantiated twice, once for reads and once for writes.
- The top level holds the class arbitration, the hazard check, the muxes and the response tracking.

Test Plan:
- Single read: rd_req_vld=4'b0100, addr 5 holding 0xA5..A5. Required: rd_req_rdy=4'b0100 the same cycle; rd_rsp_vld=4'b0100 and dat=0xA5..A5 the next cycle; then idle.
- Round-robin: all 4 readers assert vld continuously from reset. Required: grant order 0,1,2,3,0; each pulse lands one cycle after its grant.
- Class conflict, DUAL_PORT=0: reader 0 and writer 1 both vld from reset. Required: cycles alternate W,R,W,R; never both enables high together.
- Write-then-read: write 0x1234 at addr 7, then read addr 7. Required: the response data is 0x1234.
- DUAL_PORT=1 hazard: read and write to addr 3 in the same cycle. Required: the write is granted and the read is delayed one cycle; the read then returns the new data. Different addresses: both granted in the same cycle.
- Reset: assert rst_n=0 in the cycle after a read grant. Required: no rd_rsp_vld after release; pointers back to 0, so the next grant goes to index 0.
